// File: rtl/sig_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sig_gen_pkg
// Description : Shared defaults, amplitude, quadrant codes and the sine-table
//               generator used by the multi-channel NCO.
// Revision    : 1.0 - initial release
// ============================================================================
package sig_gen_pkg;

    localparam int DEF_PHASE_BITS = 32;
    localparam int DEF_N_BITS     = 16;
    localparam int DEF_LUT_BITS   = 10;

    localparam int AMP = (2 ** (DEF_N_BITS - 1)) - 1;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    localparam real C_PI = 3.14159265358979323846;

    // Elaboration-time table entry: round-half-away-from-zero of amp*sin(2*pi*k/2^lut_bits)
    function automatic int sin_entry(input int k, input int lut_bits, input int amp);
        real r;
        r = real'(amp) * $sin(2.0 * C_PI * real'(k) / real'(2 ** lut_bits));
        if (r >= 0.0) begin
            return $rtoi(r + 0.5);
        end
        return -$rtoi(0.5 - r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sig_gen_lut.sv
`default_nettype none
// ============================================================================
// Module      : sig_gen_lut
// Description : Registered cosine/sine lookup with clock enable. Build macro
//               SIG_GEN_QUARTER_WAVE_EN selects a first-quadrant table with
//               mirroring instead of the full-wave table.
// Revision    : 1.0 - initial release
// ============================================================================
module sig_gen_lut
    import sig_gen_pkg::*;
#(
    parameter int N_BITS   = DEF_N_BITS,
    parameter int LUT_BITS = DEF_LUT_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic [LUT_BITS-1:0]        i_addr,
    output logic signed [N_BITS-1:0]   o_cos,
    output logic signed [N_BITS-1:0]   o_sin
);

    localparam int c_amp = (2 ** (N_BITS - 1)) - 1;

    logic signed [N_BITS-1:0] w_cos;
    logic signed [N_BITS-1:0] w_sin;
    logic signed [N_BITS-1:0] cos_d, cos_q;
    logic signed [N_BITS-1:0] sin_d, sin_q;

`ifdef SIG_GEN_QUARTER_WAVE_EN
    localparam int c_rom_len = (2 ** (LUT_BITS - 2)) + 1;
    localparam logic [LUT_BITS-2:0] c_quarter = {1'b1, {(LUT_BITS-2){1'b0}}};

    logic signed [N_BITS-1:0] w_rom [c_rom_len];
    logic [1:0]               w_quad;
    logic [LUT_BITS-2:0]      w_fwd;
    logic [LUT_BITS-2:0]      w_rev;
    logic signed [N_BITS-1:0] w_fwd_val;
    logic signed [N_BITS-1:0] w_rev_val;

    for (genvar k = 0; k < c_rom_len; k++) begin : g_rom
        localparam logic signed [N_BITS-1:0] c_val = N_BITS'(sin_entry(k, LUT_BITS, c_amp));
        assign w_rom[k] = c_val;
    end

    // Entry 2^(LUT_BITS-2) holds the peak so the reversed index never leaves the table
    always_comb begin
        w_quad    = i_addr[LUT_BITS-1 -: 2];
        w_fwd     = {1'b0, i_addr[LUT_BITS-3:0]};
        w_rev     = c_quarter - w_fwd;
        w_fwd_val = w_rom[w_fwd];
        w_rev_val = w_rom[w_rev];
        w_sin     = w_fwd_val;
        w_cos     = w_rev_val;
        case (w_quad)
            QUAD_0: begin
                w_sin = w_fwd_val;
                w_cos = w_rev_val;
            end
            QUAD_1: begin
                w_sin = w_rev_val;
                w_cos = -w_fwd_val;
            end
            QUAD_2: begin
                w_sin = -w_fwd_val;
                w_cos = -w_rev_val;
            end
            default: begin
                w_sin = -w_rev_val;
                w_cos = w_fwd_val;
            end
        endcase
    end
`else
    localparam int c_rom_len = 2 ** LUT_BITS;
    localparam logic [LUT_BITS-1:0] c_quarter = LUT_BITS'(2 ** (LUT_BITS - 2));

    logic signed [N_BITS-1:0] w_rom [c_rom_len];
    logic [LUT_BITS-1:0]      w_cos_addr;

    for (genvar k = 0; k < c_rom_len; k++) begin : g_rom
        localparam logic signed [N_BITS-1:0] c_val = N_BITS'(sin_entry(k, LUT_BITS, c_amp));
        assign w_rom[k] = c_val;
    end

    always_comb begin
        w_cos_addr = i_addr + c_quarter;
        w_sin      = w_rom[i_addr];
        w_cos      = w_rom[w_cos_addr];
    end
`endif

    always_comb begin
        cos_d = cos_q;
        sin_d = sin_q;
        if (i_en) begin
            cos_d = w_cos;
            sin_d = w_sin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign o_cos = cos_q;
    assign o_sin = sin_q;

endmodule
`default_nettype wire

// File: rtl/sig_gen_mc.sv
`default_nettype none
// ============================================================================
// Module      : sig_gen_mc
// Description : Time-interleaved multi-channel NCO, round-robin issue, two-
//               stage pipeline with output backpressure. Table style chosen
//               by SIG_GEN_QUARTER_WAVE_EN (see sig_gen_lut).
// Revision    : 1.0 - initial release
// ============================================================================
module sig_gen_mc
    import sig_gen_pkg::*;
#(
    parameter int PHASE_BITS = DEF_PHASE_BITS,
    parameter int N_BITS     = DEF_N_BITS,
    parameter int LUT_BITS   = DEF_LUT_BITS,
    parameter int NUM_CH     = 4,
    parameter int CH_BITS    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CH_BITS-1:0]       cfg_ch,
    input  logic [PHASE_BITS-1:0]    cfg_freq_step,
    input  logic [PHASE_BITS-1:0]    cfg_phase_offset,
    input  logic                     cfg_clear_phase,
    input  logic                     m_axis_data_tready,
    output logic                     s_axis_data_tvalid,
    output logic signed [N_BITS-1:0] cosine,
    output logic signed [N_BITS-1:0] sine,
    output logic [CH_BITS-1:0]       ch_id
);

    logic [NUM_CH-1:0][PHASE_BITS-1:0] acc_d,    acc_q;
    logic [NUM_CH-1:0][PHASE_BITS-1:0] step_d,   step_q;
    logic [NUM_CH-1:0][PHASE_BITS-1:0] offset_d, offset_q;
    logic [CH_BITS-1:0]                rr_d,     rr_q;
    logic [LUT_BITS-1:0]               s1_addr_d, s1_addr_q;
    logic [CH_BITS-1:0]                s1_ch_d,   s1_ch_q;
    logic                              s1_valid_d, s1_valid_q;
    logic [CH_BITS-1:0]                ch_id_d,   ch_id_q;
    logic                              tvalid_d,  tvalid_q;

    logic                  w_adv;
    logic                  w_cfg_wr;
    logic [PHASE_BITS-1:0] w_sel_acc;
    logic [PHASE_BITS-1:0] w_sel_off;
    logic [PHASE_BITS-1:0] w_phase;

    assign cfg_ready = !reset;
    assign w_cfg_wr  = cfg_valid && cfg_ready;
    assign w_adv     = !tvalid_q || m_axis_data_tready;

    always_comb begin
        w_sel_acc = '0;
        w_sel_off = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rr_q == CH_BITS'(c)) begin
                w_sel_acc = acc_q[c];
                w_sel_off = offset_q[c];
            end
        end
        w_phase = w_sel_acc + w_sel_off;
    end

    // A config write overrides the issue-time accumulator step for the same channel
    always_comb begin
        acc_d    = acc_q;
        step_d   = step_q;
        offset_d = offset_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_adv && (rr_q == CH_BITS'(c))) begin
                acc_d[c] = acc_q[c] + step_q[c];
            end
            if (w_cfg_wr && (cfg_ch == CH_BITS'(c))) begin
                step_d[c]   = cfg_freq_step;
                offset_d[c] = cfg_phase_offset;
                if (cfg_clear_phase) begin
                    acc_d[c] = '0;
                end
            end
        end
    end

    always_comb begin
        rr_d       = rr_q;
        s1_addr_d  = s1_addr_q;
        s1_ch_d    = s1_ch_q;
        s1_valid_d = s1_valid_q;
        ch_id_d    = ch_id_q;
        tvalid_d   = tvalid_q;
        if (w_adv) begin
            rr_d       = (rr_q == CH_BITS'(NUM_CH - 1)) ? '0 : rr_q + CH_BITS'(1);
            s1_addr_d  = w_phase[PHASE_BITS-1 -: LUT_BITS];
            s1_ch_d    = rr_q;
            s1_valid_d = 1'b1;
            ch_id_d    = s1_ch_q;
            tvalid_d   = s1_valid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            step_q     <= '0;
            offset_q   <= '0;
            rr_q       <= '0;
            s1_addr_q  <= '0;
            s1_ch_q    <= '0;
            s1_valid_q <= 1'b0;
            ch_id_q    <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            step_q     <= step_d;
            offset_q   <= offset_d;
            rr_q       <= rr_d;
            s1_addr_q  <= s1_addr_d;
            s1_ch_q    <= s1_ch_d;
            s1_valid_q <= s1_valid_d;
            ch_id_q    <= ch_id_d;
            tvalid_q   <= tvalid_d;
        end
    end

    sig_gen_lut #(
        .N_BITS   (N_BITS),
        .LUT_BITS (LUT_BITS)
    ) u_lut (
        .clk    (clk),
        .rst    (reset),
        .i_en   (w_adv),
        .i_addr (s1_addr_q),
        .o_cos  (cosine),
        .o_sin  (sine)
    );

    assign s_axis_data_tvalid = tvalid_q;
    assign ch_id              = ch_id_q;

endmodule
`default_nettype wire

// File: tb/tb_sig_gen_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sig_gen_mc
// Description : Directed self-checking bench for sig_gen_mc (4 channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sig_gen_mc;

    localparam real C_PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [1:0]         cfg_ch;
    logic [31:0]        cfg_freq_step;
    logic [31:0]        cfg_phase_offset;
    logic               cfg_clear_phase;
    logic               m_axis_data_tready;
    logic               s_axis_data_tvalid;
    logic signed [15:0] cosine;
    logic signed [15:0] sine;
    logic [1:0]         ch_id;

    logic [31:0] st  [4];
    logic [31:0] off [4];
    int          exp_cos [4];
    int          exp_sin [4];

    int n_checks = 0;
    int n_pass   = 0;

    sig_gen_mc #(
        .PHASE_BITS (32),
        .N_BITS     (16),
        .LUT_BITS   (10),
        .NUM_CH     (4),
        .CH_BITS    (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .cfg_ch             (cfg_ch),
        .cfg_freq_step      (cfg_freq_step),
        .cfg_phase_offset   (cfg_phase_offset),
        .cfg_clear_phase    (cfg_clear_phase),
        .m_axis_data_tready (m_axis_data_tready),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .cosine             (cosine),
        .sine               (sine),
        .ch_id              (ch_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sin_ref(input int k);
        real r;
        r = 32767.0 * $sin(2.0 * C_PI * real'(k) / 1024.0);
        if (r >= 0.0) begin
            return $rtoi(r + 0.5);
        end
        return -$rtoi(0.5 - r);
    endfunction

    // Reset, run until channel 3 sits in stage 1, stall, program all channels
    // with clear, then flush the stale sample: next beat is channel 0, fresh.
    task automatic restart();
        reset              = 1'b1;
        cfg_valid          = 1'b0;
        cfg_clear_phase    = 1'b0;
        m_axis_data_tready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        m_axis_data_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cfg_valid        = 1'b1;
            cfg_ch           = 2'(c);
            cfg_freq_step    = st[c];
            cfg_phase_offset = off[c];
            cfg_clear_phase  = 1'b1;
            tick();
        end
        cfg_valid          = 1'b0;
        cfg_clear_phase    = 1'b0;
        m_axis_data_tready = 1'b1;
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset              = 1'b1;
        cfg_valid          = 1'b0;
        cfg_ch             = 2'd0;
        cfg_freq_step      = '0;
        cfg_phase_offset   = '0;
        cfg_clear_phase    = 1'b0;
        m_axis_data_tready = 1'b1;

        // ---------------- reset and start-up latency ----------------
        tick();
        tick();
        check("rst_tvalid", s_axis_data_tvalid, 0);
        check("rst_cos", cosine, 0);
        check("rst_sin", sine, 0);
        check("rst_ch", ch_id, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        reset = 1'b0;
        #1;
        check("cfg_ready", cfg_ready, 1);
        tick();
        check("lat_edge1_tvalid", s_axis_data_tvalid, 0);
        tick();
        check("lat_edge2_tvalid", s_axis_data_tvalid, 1);
        check("lat_edge2_ch", ch_id, 0);
        check("lat_edge2_cos", cosine, 32767);
        check("lat_edge2_sin", sine, 0);
        for (int b = 1; b <= 4; b++) begin
            tick();
            check("rr_ch", ch_id, b % 4);
            check("rr_tvalid", s_axis_data_tvalid, 1);
        end
        reset = 1'b1;
        #1;
        check("midrst_tvalid", s_axis_data_tvalid, 0);
        check("midrst_cos", cosine, 0);

        // ---------------- quadrature on channel 0, then clear ----------------
        st  = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        off = '{32'h0, 32'h0, 32'h0, 32'h0};
        exp_cos = '{32767, 0, -32767, 0};
        exp_sin = '{0, 32767, 0, -32767};
        restart();
        for (int b = 0; b < 16; b++) begin
            tick();
            check("quad_ch", ch_id, b % 4);
            if (b % 4 == 0) begin
                check("quad_cos", cosine, exp_cos[(b / 4) % 4]);
                check("quad_sin", sine, exp_sin[(b / 4) % 4]);
            end
        end
        repeat (5) tick();
        check("pre_clr_ch", ch_id, 0);
        check("pre_clr_cos", cosine, 0);
        check("pre_clr_sin", sine, 32767);
        cfg_valid        = 1'b1;
        cfg_ch           = 2'd0;
        cfg_freq_step    = 32'h4000_0000;
        cfg_phase_offset = 32'h0;
        cfg_clear_phase  = 1'b1;
        tick();
        cfg_valid       = 1'b0;
        cfg_clear_phase = 1'b0;
        repeat (3) tick();
        check("clr_ch", ch_id, 0);
        check("clr_cos", cosine, 32767);
        check("clr_sin", sine, 0);
        repeat (4) tick();
        check("clr_next_cos", cosine, 0);
        check("clr_next_sin", sine, 32767);

        // ---------------- round-robin offsets, backpressure, same-cycle write ----------------
        st  = '{32'h0, 32'h0, 32'h0, 32'h0};
        off = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        restart();
        for (int b = 0; b < 8; b++) begin
            tick();
            check("ofs_ch", ch_id, b % 4);
            check("ofs_sin", sine, exp_sin[b % 4]);
            check("ofs_cos", cosine, exp_cos[b % 4]);
        end
        m_axis_data_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_tvalid", s_axis_data_tvalid, 1);
            check("bp_ch", ch_id, 3);
            check("bp_sin", sine, -32767);
        end
        m_axis_data_tready = 1'b1;
        for (int b = 8; b < 13; b++) begin
            tick();
            check("bp_resume_ch", ch_id, b % 4);
            check("bp_resume_sin", sine, exp_sin[b % 4]);
        end
        cfg_valid        = 1'b1;
        cfg_ch           = 2'd2;
        cfg_freq_step    = 32'h0;
        cfg_phase_offset = 32'h0;
        cfg_clear_phase  = 1'b0;
        tick();
        cfg_valid = 1'b0;
        check("same_b13_ch", ch_id, 1);
        tick();
        check("same_old_ch", ch_id, 2);
        check("same_old_cos", cosine, -32767);
        check("same_old_sin", sine, 0);
        repeat (4) tick();
        check("same_new_ch", ch_id, 2);
        check("same_new_cos", cosine, 32767);
        check("same_new_sin", sine, 0);

        // ---------------- negative step with wrap ----------------
        st  = '{32'hFFF0_0000, 32'h0, 32'h0, 32'h0};
        off = '{32'h0, 32'h0, 32'h0, 32'h0};
        exp_cos = '{32767, 32766, 32766, 32766};
        exp_sin = '{0, -201, -201, -201};
        restart();
        for (int b = 0; b < 13; b++) begin
            tick();
            if (b % 4 == 0) begin
                check("neg_sin", sine, exp_sin[b / 4]);
                check("neg_cos", cosine, exp_cos[b / 4]);
            end
        end

        // ---------------- full-table sweep, one address per channel-0 issue ----------------
        st  = '{32'h0040_0000, 32'h0, 32'h0, 32'h0};
        off = '{32'h0, 32'h0, 32'h0, 32'h0};
        restart();
        for (int b = 0; b < 4096; b++) begin
            tick();
            if (b % 4 == 0) begin
                check("sweep_sin", sine, sin_ref(b / 4));
                check("sweep_cos", cosine, sin_ref(((b / 4) + 256) % 1024));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sig_gen_mc.md
Name: sig_gen_mc

Overview:
- Multi-channel, time-interleaved NCO. Successor to the single-channel sig_gen.
- Each of NUM_CH channels has its own phase accumulator, frequency step and phase offset, all runtime-programmable through a config port.
- Emits one cosine/sine pair per accepted output beat, round-robin across channels, tagged with the channel index.
- Feeds the CAF frequency-shift mixers, which need several independent Doppler bins from one block.

Parameters:
- PHASE_BITS, 32, phase accumulator width.
- N_BITS, 16, signed output sample width.
- LUT_BITS, 10, phase MSBs used as the table address (full wave = 2^LUT_BITS entries).
- NUM_CH, 4, number of channels (power of two, >=1).
- CH_BITS, max(1,$clog2(NUM_CH)), channel tag width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cfg_valid  in  1  config write strobe
- cfg_ready  out  1  config accept
- cfg_ch  in  CH_BITS  target channel
- cfg_freq_step  in  PHASE_BITS  new frequency step
- cfg_phase_offset  in  PHASE_BITS  new phase offset
- cfg_clear_phase  in  1  zero the channel accumulator on this write
- m_axis_data_tready  in  1  downstream ready
- s_axis_data_tvalid  out  1  output sample valid
- cosine  out  N_BITS  signed cosine sample
- sine  out  N_BITS  signed sine sample
- ch_id  out  CH_BITS  channel of the current sample

Behaviour:
- Reset (async, active-high) clears all of the following to 0:
  - accumulators, freq steps, offsets, round-robin pointer, pipeline valids;
  - s_axis_data_tvalid, cosine, sine, ch_id.
- cfg_ready is 1 whenever reset is low. A write occurs when cfg_valid && cfg_ready.
- Pipeline advance: adv = !s_axis_data_tvalid || m_axis_data_tready. When adv is 0, every stage and every accumulator holds. tvalid never depends on tready.
- Issue happens on every adv cycle for channel c = rr pointer:
  - S1 captures addr = (acc[c] + offset[c]) [PHASE_BITS-1 -: LUT_BITS], plus ch = c and valid = 1.
  - acc[c] <= acc[c] + step[c], mod 2^PHASE_BITS with silent wrap.
  - rr <= (rr+1) mod NUM_CH.
- S2 (output registers), on adv: cosine/sine <= LUT(S1.addr); ch_id <= S1.ch; s_axis_data_tvalid <= S1.valid.
- Latency: 2 clk from issue to output. The first valid output appears at the 2nd rising edge after reset deasserts.
- Channel c's first sample after reset or clear is at phase = offset[c].
- LUT contents:
  - sine[k] = round((2^(N_BITS-1)-1) * sin(2πk/2^LUT_BITS));
  - cosine[k] = sine[(k + 2^(LUT_BITS-2)) mod 2^LUT_BITS].
  - Phase LSBs are truncated, with no interpolation.
- Config write to channel c takes effect on the next issue of c:
  - step and offset are updated;
  - if cfg_clear_phase = 1, acc[c] <= 0.
- Config write in the same cycle as an issue of c:
  - the issued sample uses the old offset;
  - the config write wins the accumulator update: acc[c] <= 0 if clear, else acc[c] + old step;
  - new step and offset apply from the following issue.
- Writes while stalled are accepted and applied normally. An accumulator is never modified by a stall.
- Reset mid-stream discards in-flight samples: tvalid drops immediately (async).

Optional Feature:
- Macro: SIG_GEN_QUARTER_WAVE_EN.
- Defined:
  - LUT stores only 2^(LUT_BITS-2)+1 entries of the first quadrant (0..π/2 inclusive);
  - sine/cosine are reconstructed by quadrant mirroring and negation of the 2 address MSBs;
  - output is bit-identical to the full table, with latency unchanged at 2.
- Undefined: full 2^LUT_BITS-entry table.

Decomposition:
- Package sig_gen_pkg holds:
  - default PHASE_BITS / N_BITS / LUT_BITS;
  - the AMP constant (2^(N_BITS-1)-1);
  - the quadrant encoding constants.
- One sub-module, sig_gen_lut:
  - address in, registered signed cosine/sine out, with enable = adv;
  - contains the quarter-wave option;
  - instantiated once and shared across channels.

Test Plan:
- Reset: hold reset with tready=1, then release. All outputs read 0 during reset; tvalid first rises at the 2nd edge after release; ch_id sequence is 0,1,2,3,0…
- Quadrature: NUM_CH=1, step=2^30, offset 0. Cosine = 32767, 0, -32767, 0, …; sine = 0, 32767, 0, -32767, … (repeating).
- Backpressure: tready low for 5 cycles mid-stream. Sample and ch_id are held stable, and the sequence resumes with no gap or duplicate when tready returns to 1.
- Round-robin + offsets: NUM_CH=4, all steps 0, offsets 0, 2^30, 2^31, 3·2^30. Sine per beat = 0, 32767, 0, -32767 with ch_id 0..3, repeating.
- Wrap and clear:
  - step=0xFFFFFFFF·2^20 (negative): sine samples go negative first.
  - Mid-run write with cfg_clear_phase=1 and offset 0: that channel's next output is cosine 32767, sine 0.
  - Same-cycle write+issue: the issued sample uses the old offset.
- Quarter-wave: run all scenarios with and without SIG_GEN_QUARTER_WAVE_EN, plus a sweep over all 2^LUT_BITS addresses. Outputs must be bit-identical.
